// File: rtl/alpha_recursion.sv
// Forward (alpha) max-log recursion over one block of branch metrics, one trellis step per clock.
// The trellis tables arrive flattened: entry [s][u] sits at index (s*INPUT_SYMBOLS + u).
module alpha_recursion #(
    parameter int BITS            = 16,
    parameter     PRECISION       = "HALF",
    parameter int BITS_PER_SYMBOL = 2,
    parameter int STATES          = 4,
    parameter int OUTPUT_SYMBOLS  = 4,
    parameter int SYMBOLS         = 10
) (
    input  logic                                                         clk,
    input  logic                                                         reset,
    input  logic [STATES*(2**BITS_PER_SYMBOL)*$clog2(STATES)-1:0]         trellis_next_state,
    input  logic [STATES*(2**BITS_PER_SYMBOL)*$clog2(OUTPUT_SYMBOLS)-1:0] trellis_output_symbol,
    input  logic                                                         in_valid,
    output logic                                                         in_ready,
    input  logic [SYMBOLS*OUTPUT_SYMBOLS*BITS-1:0]                        branch_metric,
    output logic                                                         out_valid,
    output logic [STATES*(SYMBOLS+1)*BITS-1:0]                            AlphaMetric,
    output logic [SYMBOLS*OUTPUT_SYMBOLS*BITS-1:0]                        branch_metric_out
);

    localparam int INPUT_SYMBOLS = 2**BITS_PER_SYMBOL;
    localparam int SW            = $clog2(STATES);
    localparam int OW            = $clog2(OUTPUT_SYMBOLS);
    localparam int KW            = $clog2(SYMBOLS + 1);
    // Arithmetic below is IEEE half precision only.
    localparam logic [BITS-1:0] MINUS_INFINITY = (PRECISION == "HALF") ? 16'hFC00 : 16'hFFFF;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d, k_next;
    logic            accept;
    logic [SYMBOLS*OUTPUT_SYMBOLS*BITS-1:0] bm_q;
    logic [BITS-1:0] alpha_q [STATES][SYMBOLS+1];
    logic [BITS-1:0] cur     [STATES];
    logic [BITS-1:0] bm_row  [OUTPUT_SYMBOLS];
    logic [BITS-1:0] cand    [STATES][INPUT_SYMBOLS];
    logic [BITS-1:0] new_col [STATES];

    // Every finite half is an integer multiple of 2^-24 below 2^16, so a 42-bit
    // signed fixed-point sum is exact and a single RNE rounding gives the true result.
    function automatic logic [41:0] h2fix(input logic [15:0] x);
        logic [41:0] mag;
        logic [4:0]  e;
        e   = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        mag = {31'd0, (x[14:10] != 5'd0), x[9:0]} << (e - 5'd1);
        return x[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] hadd(input logic [15:0] a, input logic [15:0] b);
        logic [41:0] sum, mag, rem_mask;
        logic [5:0]  p, sh;
        logic [10:0] m;
        logic [4:0]  e;
        logic [15:0] ef;
        logic        sgn, guard, sticky, rnd;
        if (a[14:10] == 5'h1F && b[14:10] == 5'h1F && a[15] != b[15])
            return 16'h7E00;
        if (a[14:10] == 5'h1F)
            return a;
        if (b[14:10] == 5'h1F)
            return b;
        sum = h2fix(a) + h2fix(b);
        sgn = sum[41];
        mag = sgn ? -sum : sum;
        if (mag == '0)
            return {a[15] & b[15], 15'd0};
        p = '0;
        for (int unsigned i = 0; i < 42; i++)
            if (mag[i]) p = 6'(i);
        if (p <= 6'd10)
            return {sgn, mag[14:0]};
        if (p >= 6'd40)
            return {sgn, 15'h7C00};
        sh       = p - 6'd10;
        m        = 11'(mag >> sh);
        rem_mask = (42'd1 << (sh - 6'd1)) - 42'd1;
        guard    = mag[sh - 6'd1];
        sticky   = |(mag & rem_mask);
        rnd      = guard & (sticky | m[0]);
        e        = 5'(p - 6'd9);
        // A rounding carry out of the fraction bumps the exponent, reaching infinity at the top.
        ef       = {1'b0, e, m[9:0]} + 16'(rnd);
        return {sgn, ef[14:0]};
    endfunction

    function automatic logic [15:0] hmax(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] ka, kb;
        ka = a[15] ? ~a : {1'b1, a[14:0]};
        kb = b[15] ? ~b : {1'b1, b[14:0]};
        return (kb > ka) ? b : a;
    endfunction

    assign in_ready = (state_q != RUN);
    assign out_valid = (state_q == DONE);
    assign accept = in_valid && in_ready;
    assign k_next = k_q + KW'(1);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = RUN;
                k_d     = '0;
            end
            RUN: begin
                k_d = k_next;
                if (k_q == KW'(SYMBOLS - 1)) state_d = DONE;
            end
            DONE: begin
                k_d     = '0;
                state_d = in_valid ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned s = 0; s < STATES; s++)
            cur[s] = alpha_q[s][k_q];
        for (int unsigned o = 0; o < OUTPUT_SYMBOLS; o++)
            bm_row[o] = bm_q[(32'(k_q) * OUTPUT_SYMBOLS + o) * BITS +: BITS];
        for (int unsigned s = 0; s < STATES; s++)
            for (int unsigned u = 0; u < INPUT_SYMBOLS; u++)
                cand[s][u] = hadd(cur[s],
                    bm_row[trellis_output_symbol[(s * INPUT_SYMBOLS + u) * OW +: OW]]);
        for (int unsigned sp = 0; sp < STATES; sp++) begin
            new_col[sp] = MINUS_INFINITY;
            for (int unsigned s = 0; s < STATES; s++)
                for (int unsigned u = 0; u < INPUT_SYMBOLS; u++)
                    if (trellis_next_state[(s * INPUT_SYMBOLS + u) * SW +: SW] == SW'(sp))
                        new_col[sp] = hmax(new_col[sp], cand[s][u]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            bm_q    <= '0;
            for (int unsigned s = 0; s < STATES; s++)
                for (int unsigned k = 0; k <= SYMBOLS; k++)
                    alpha_q[s][k] <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept) begin
                bm_q <= branch_metric;
                for (int unsigned s = 0; s < STATES; s++)
                    alpha_q[s][0] <= (s == 0) ? '0 : MINUS_INFINITY;
            end else if (state_q == RUN) begin
                for (int unsigned s = 0; s < STATES; s++)
                    alpha_q[s][k_next] <= new_col[s];
            end
        end
    end

    for (genvar s = 0; s < STATES; s++) begin : g_state
        for (genvar k = 0; k <= SYMBOLS; k++) begin : g_col
            assign AlphaMetric[(s * (SYMBOLS + 1) + k) * BITS +: BITS] = alpha_q[s][k];
        end
    end

    assign branch_metric_out = bm_q;

endmodule

// File: tb/tb_alpha_recursion.sv
// Scoreboard bench for alpha_recursion: a 10-step instance plus a 1-step instance, sharing a
// 4-state trellis where next_state[s][u] = {s[0],u[0]} and output_symbol[s][u] = (s+u) mod 4.
module tb_alpha_recursion;

    localparam int NS = 10;
    localparam logic [15:0] MIN = 16'hFC00;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  ns_flat, os_flat;
    logic         in_valid, in_ready, out_valid;
    logic [639:0] branch_metric, branch_metric_out;
    logic [703:0] AlphaMetric;
    logic         in_valid2, in_ready2, out_valid2;
    logic [63:0]  branch_metric2, branch_metric_out2;
    logic [127:0] AlphaMetric2;

    typedef struct {
        logic [703:0] a;
        logic [639:0] b;
        int           cyc;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    alpha_recursion #(.BITS(16), .PRECISION("HALF"), .BITS_PER_SYMBOL(2), .STATES(4),
                      .OUTPUT_SYMBOLS(4), .SYMBOLS(NS)) dut (
        .clk(clk), .reset(reset),
        .trellis_next_state(ns_flat), .trellis_output_symbol(os_flat),
        .in_valid(in_valid), .in_ready(in_ready), .branch_metric(branch_metric),
        .out_valid(out_valid), .AlphaMetric(AlphaMetric), .branch_metric_out(branch_metric_out)
    );

    alpha_recursion #(.BITS(16), .PRECISION("HALF"), .BITS_PER_SYMBOL(2), .STATES(4),
                      .OUTPUT_SYMBOLS(4), .SYMBOLS(1)) dut2 (
        .clk(clk), .reset(reset),
        .trellis_next_state(ns_flat), .trellis_output_symbol(os_flat),
        .in_valid(in_valid2), .in_ready(in_ready2), .branch_metric(branch_metric2),
        .out_valid(out_valid2), .AlphaMetric(AlphaMetric2), .branch_metric_out(branch_metric_out2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nsf(input int s, input int u);
        return (s % 2) * 2 + (u % 2);
    endfunction

    function automatic int osf(input int s, input int u);
        return (s + u) % 4;
    endfunction

    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else repeat (-n) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real v;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) v = real'(int'(h[9:0])) * pow2(-24);
        else        v = real'(1024 + int'(h[9:0])) * pow2(e - 25);
        return h[15] ? -v : v;
    endfunction

    function automatic int rne(input real x);
        real f, d;
        int  n;
        f = $floor(x);
        d = x - f;
        n = $rtoi(f);
        if (d > 0.5 || (d == 0.5 && (n % 2) == 1)) n++;
        return n;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        real a;
        int  n, e;
        logic sg;
        if (r == 0.0) return 16'h0000;
        sg = (r < 0.0);
        a  = sg ? -r : r;
        if (a < pow2(-14)) return {sg, 15'(rne(a * pow2(24)))};
        e = -14;
        while (e <= 15 && a >= pow2(e + 1)) e++;
        if (e > 15) return {sg, 15'h7C00};
        n = rne(a / pow2(e) * 1024.0);
        if (n == 2048) begin
            n = 1024;
            e++;
        end
        if (e > 15) return {sg, 15'h7C00};
        return {sg, 5'(e + 15), 10'(n - 1024)};
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        if (a == MIN || b == MIN) return MIN;
        return r2h(h2r(a) + h2r(b));
    endfunction

    function automatic logic [15:0] fmax(input logic [15:0] a, input logic [15:0] b);
        if (a == MIN) return b;
        if (b == MIN) return a;
        return (h2r(a) >= h2r(b)) ? a : b;
    endfunction

    // Golden max-log forward recursion, output laid out as (s*(nsym+1)+k)*16.
    function automatic logic [703:0] model(input logic [639:0] bm, input int nsym);
        logic [15:0]  al [4][11];
        logic [15:0]  acc;
        logic [703:0] r;
        for (int s = 0; s < 4; s++) al[s][0] = (s == 0) ? 16'h0000 : MIN;
        for (int k = 0; k < nsym; k++)
            for (int sp = 0; sp < 4; sp++) begin
                acc = MIN;
                for (int s = 0; s < 4; s++)
                    for (int u = 0; u < 4; u++)
                        if (nsf(s, u) == sp)
                            acc = fmax(acc, fadd(al[s][k], bm[(k * 4 + osf(s, u)) * 16 +: 16]));
                al[sp][k + 1] = acc;
            end
        r = '0;
        for (int s = 0; s < 4; s++)
            for (int k = 0; k <= nsym; k++)
                r[(s * (nsym + 1) + k) * 16 +: 16] = al[s][k];
        return r;
    endfunction

    // All-zero metrics: column 0 {0,MIN,MIN,MIN}, column 1 {0,0,MIN,MIN}, then all zero.
    function automatic logic [703:0] zero_exp();
        logic [703:0] r;
        r = '0;
        for (int s = 1; s < 4; s++) r[(s * 11) * 16 +: 16] = MIN;
        for (int s = 2; s < 4; s++) r[(s * 11 + 1) * 16 +: 16] = MIN;
        return r;
    endfunction

    function automatic logic [63:0] col(input logic [703:0] v, input int k, input int nsym);
        logic [63:0] c;
        for (int s = 0; s < 4; s++) c[s * 16 +: 16] = v[(s * (nsym + 1) + k) * 16 +: 16];
        return c;
    endfunction

    function automatic logic [639:0] rand_block();
        logic [639:0] b;
        for (int i = 0; i < 40; i++)
            b[i * 16 +: 16] = {1'($urandom), 5'($urandom_range(19, 10)), 10'($urandom)};
        return b;
    endfunction

    task automatic chk(input string name, input logic [703:0] act, input logic [703:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s @cycle %0d: actual %0h required %0h", name, cyc, act, req);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (out_valid) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL out_valid_unexpected @cycle %0d: actual 1 required 0", cyc);
            end else begin
                e = q.pop_front();
                chk("out_valid_cycle", 704'(cyc), 704'(e.cyc));
                for (int k = 0; k <= NS; k++)
                    chk($sformatf("alpha_col%0d", k), 704'(col(AlphaMetric, k, NS)),
                        704'(col(e.a, k, NS)));
                chk("branch_metric_out", 704'(branch_metric_out), 704'(e.b));
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (out_valid2) begin
            if (q2.size() == 0) begin
                n_total++;
                $display("FAIL dut2_out_valid_unexpected @cycle %0d: actual 1 required 0", cyc);
            end else begin
                e = q2.pop_front();
                chk("dut2_out_valid_cycle", 704'(cyc), 704'(e.cyc));
                for (int k = 0; k <= 1; k++)
                    chk($sformatf("dut2_alpha_col%0d", k), 704'(col(704'(AlphaMetric2), k, 1)),
                        704'(col(e.a, k, 1)));
                chk("dut2_branch_metric_out", 704'(branch_metric_out2), 704'(e.b[63:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40 && !in_ready; i++) tick();
    endtask

    task automatic send(input logic [639:0] blk, input logic [703:0] ea, input bit push);
        exp_t e;
        chk("accept_ready", 704'(in_ready), 704'(1));
        in_valid      = 1'b1;
        branch_metric = blk;
        if (push) begin
            e.a   = ea;
            e.b   = blk;
            e.cyc = cyc + NS + 1;
            q.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [639:0] blk, blk_b;
        exp_t e2;
        for (int s = 0; s < 4; s++)
            for (int u = 0; u < 4; u++) begin
                ns_flat[(s * 4 + u) * 2 +: 2] = 2'(nsf(s, u));
                os_flat[(s * 4 + u) * 2 +: 2] = 2'(osf(s, u));
            end
        reset = 1'b1; in_valid = 1'b0; branch_metric = '0;
        in_valid2 = 1'b0; branch_metric2 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            chk("reset_in_ready", 704'(in_ready), 704'(1));
            chk("reset_out_valid", 704'(out_valid), 704'(0));
            chk("reset_alpha", AlphaMetric, '0);
            chk("reset_bm_out", 704'(branch_metric_out), '0);
            tick();
        end

        send('0, zero_exp(), 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("run_in_ready_low", 704'(in_ready), 704'(0));
            tick();
        end
        chk("done_in_ready", 704'(in_ready), 704'(1));
        chk("done_out_valid", 704'(out_valid), 704'(1));
        tick();

        // One step: column 1 = {max(1,3), max(2,0), MIN, MIN}.
        chk("dut2_accept_ready", 704'(in_ready2), 704'(1));
        in_valid2      = 1'b1;
        branch_metric2 = 64'h0000_4200_4000_3C00;
        e2.a   = 704'({16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'h4000, 16'hFC00, 16'h4200, 16'h0000});
        e2.b   = 640'(branch_metric2);
        e2.cyc = cyc + 2;
        q2.push_back(e2);
        tick();
        in_valid2 = 1'b0;
        chk("dut2_run_in_ready_low", 704'(in_ready2), 704'(0));
        tick();
        tick();

        blk = 640'(64'h0000_4200_4000_3C00);
        send(blk, model(blk, NS), 1'b1);
        wait_ready();

        blk   = rand_block();
        blk_b = rand_block();
        send(blk, model(blk, NS), 1'b1);
        in_valid      = 1'b1;
        branch_metric = blk_b;
        for (int i = 0; i < 10; i++) begin
            chk("b2b_ignored_ready_low", 704'(in_ready), 704'(0));
            tick();
        end
        chk("b2b_done_ready", 704'(in_ready), 704'(1));
        chk("b2b_bm_out_held", 704'(branch_metric_out), 704'(blk));
        e2.a = model(blk_b, NS); e2.b = blk_b; e2.cyc = cyc + NS + 1;
        q.push_back(e2);
        tick();
        in_valid = 1'b0;
        chk("b2b_bm_out_switched", 704'(branch_metric_out), 704'(blk_b));
        wait_ready();

        // Reset during RUN: the partial block must never produce out_valid.
        blk = rand_block();
        send(blk, '0, 1'b0);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrun_reset_in_ready", 704'(in_ready), 704'(1));
        chk("midrun_reset_out_valid", 704'(out_valid), 704'(0));
        chk("midrun_reset_alpha", AlphaMetric, '0);
        chk("midrun_reset_bm_out", 704'(branch_metric_out), '0);
        blk = rand_block();
        send(blk, model(blk, NS), 1'b1);
        wait_ready();

        reset = 1'b1; in_valid = 1'b1; branch_metric = rand_block();
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk("reset_wins_in_ready", 704'(in_ready), 704'(1));
        chk("reset_wins_bm_out", 704'(branch_metric_out), '0);
        chk("reset_wins_alpha", AlphaMetric, '0);
        repeat (12) tick();

        for (int i = 0; i < 200; i++) begin
            blk = rand_block();
            wait_ready();
            send(blk, model(blk, NS), 1'b1);
        end

        for (int i = 0; i < 60 && (q.size() != 0 || q2.size() != 0); i++) tick();
        chk("scoreboard_drained", 704'(q.size() + q2.size()), '0);
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alpha_recursion.md
Name: alpha_recursion

Overview:
- Forward (alpha) recursion stage of the max-product (max-log) SISO decoder.
- Sits directly upstream of max_product. Takes one block of branch metrics and computes the full forward metric array AlphaMetric[STATES][SYMBOLS+1].
- Then presents that array, together with a registered copy of the branch metrics, to max_product as one aligned frame with a single out_valid strobe.
- Processes one trellis step per clock.

Parameters:
- BITS, 16, metric word width.
- PRECISION, "HALF", floating format of metrics. Passed to the codebase float add/max/set_value primitives.
- BITS_PER_SYMBOL, 2, input bits per trellis step. Equals log2(INPUT_SYMBOLS).
- STATES, 4, trellis states.
- OUTPUT_SYMBOLS, 4, distinct branch output symbols.
- SYMBOLS, 10, trellis steps per block.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- trellis  interface  trellis_if  supplies next_state[state][input] and output_symbol[state][input].
- in_valid  input  1  branch_metric holds a new block this cycle.
- in_ready  output  1  block accepts in_valid this cycle.
- branch_metric  input  [BITS-1:0] x [SYMBOLS][OUTPUT_SYMBOLS]  log-domain branch metrics.
- out_valid  output  1  one-cycle strobe: outputs below are a complete frame.
- AlphaMetric  output  [BITS-1:0] x [STATES][SYMBOLS+1]  forward metrics; column k is before step k.
- branch_metric_out  output  [BITS-1:0] x [SYMBOLS][OUTPUT_SYMBOLS]  captured copy of the accepted branch_metric.

Behaviour:
- All arithmetic is in PRECISION floating point using the codebase float add and float max primitives. Both are combinational, one add stage plus a max tree per state per cycle.
- MINUS_INFINITY comes from set_value with VALUE="MIN".
- No normalization is applied.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 captures branch_metric into an internal register, which also drives branch_metric_out.
  - Same edge loads column 0: state 0 = 0.0, all other states = MINUS_INFINITY.
  - Step counter k is cleared to 0 and the FSM goes to RUN.
- RUN:
  - in_ready=0.
  - Each cycle computes column k+1. For each state s', alpha[s'][k+1] = max over all (s,u) with next_state[s][u]==s' of alpha[s][k] + bm[k][output_symbol[s][u]].
  - A state with no predecessor gets MINUS_INFINITY.
  - k increments each cycle. After column SYMBOLS is written, the FSM goes to DONE.
- DONE:
  - out_valid=1 for exactly this cycle; in_ready=1.
  - in_valid=1 here accepts the next block, same actions as IDLE, and goes to RUN. Otherwise the FSM goes to IDLE.
- Latency: accept at cycle T gives out_valid at T+SYMBOLS+1.
- Sustained throughput is one block per SYMBOLS+1 cycles.
- Hold rules:
  - AlphaMetric and branch_metric_out remain stable from out_valid until the next acceptance edge.
  - Columns are written in place during RUN, so values are only guaranteed at out_valid.
  - max_product must sample its inputs on out_valid.
- in_valid while in_ready=0 is ignored. The block is not captured and state is unchanged; the upstream must hold the block or retry.
- Ties in max: either operand may be selected (values are equal).
- NaN inputs are out of scope.
- Reset, at any state including mid-RUN:
  - next cycle: FSM=IDLE, in_ready=1, out_valid=0, k=0.
  - AlphaMetric all 0 and branch_metric_out all 0.
  - A partially computed block is discarded and no out_valid is produced for it.
- Reset and in_valid in the same cycle: reset wins and the block is not accepted.
- Outputs after reset with no block ever accepted: all zero, out_valid=0.

Test Plan:
- Reset then idle: assert reset 2 cycles, release → in_ready=1, out_valid=0, all AlphaMetric/branch_metric_out = 0x0000 for 20 cycles.
- All-zero metrics, default 4-state memory-2 trellis:
  - Stimulus: accept at T.
  - Required: out_valid only at T+11.
  - Column 0 = {0,MIN,MIN,MIN}.
  - Column 1: 0x0000 at next_state[0][u] for all u, MIN elsewhere.
  - Columns 2..10 are all 0x0000.
  - in_ready=0 during T+1..T+10.
- Single-step check, SYMBOLS=1:
  - Stimulus: bm[0]={1.0(0x3C00),2.0(0x4000),3.0(0x4200),0.0}.
  - Required: column 1 state next_state[0][u] = bm[0][output_symbol[0][u]]; unreachable states = MINUS_INFINITY. Bench compares to a reference model.
  - out_valid at T+2.
- Back-to-back: second in_valid held from T+1 →
  - ignored T+1..T+10;
  - accepted at T+11 (DONE cycle);
  - out_valid at T+11 and T+22;
  - branch_metric_out switches at T+12.
- Reset mid-run: reset at T+5 → no out_valid at T+11, outputs zero at T+6, new block accepted at T+6 completes at T+17.
- Random blocks: 200 random finite half-precision blocks → every AlphaMetric column matches the golden max-log forward recursion bit-exactly, using the same float primitives.
